// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: time-shares one combinational single-precision divider between
// N_REQ requesters. Round-robin grant, operands held for DIV_CYCLES settle cycles,
// quotient captured and returned on a shared response bus tagged with the owner ID.
module fp_div_arbiter #(
    parameter int unsigned N_REQ      = 4,   // 2..8
    parameter int unsigned ID_W       = 2,   // ceil(log2(N_REQ)), min 1
    parameter int unsigned DIV_CYCLES = 4    // 1..255
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Requester side
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,

    // Shared divider
    output logic [31:0]           div_a_operand,
    output logic [31:0]           div_b_operand,
    input  logic [31:0]           div_result,
    input  logic                  div_exception,

    // Response bus
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_result,
    output logic                  resp_exception,
    output logic                  resp_dbz,

    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    // Requester count at the width of the wrap-around sum.
    localparam logic [ID_W:0] NReqW     = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0] LastId  = ID_W'(N_REQ - 1);
    localparam logic [7:0]    CntLoad   = 8'(DIV_CYCLES - 1);

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [31:0]     div_a_q, div_b_q;
    logic [ID_W-1:0] resp_id_q;
    logic [31:0]     resp_result_q;
    logic            resp_exc_q;
    logic            resp_dbz_q;
    logic            resp_valid_q;

    logic [2*N_REQ-1:0] valid_dbl;
    logic [N_REQ-1:0]   valid_rot;
    logic               grant_vld;
    logic [ID_W:0]      grant_off;
    logic [ID_W:0]      grant_sum;
    logic [ID_W-1:0]    grant_id;
    logic [31:0]        sel_a, sel_b;

    logic accept;
    logic capture;
    logic resp_done;

    // Rotate the valid vector so bit k is requester (ptr + k) mod N_REQ.
    assign valid_dbl = {req_valid, req_valid};
    assign valid_rot = N_REQ'(valid_dbl >> ptr_q);

    // Round-robin search: lowest rotated offset with a valid request wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                grant_vld = 1'b1;
                grant_off = (ID_W + 1)'(k);
            end
        end
        grant_sum = {1'b0, ptr_q} + grant_off;
        grant_id  = (grant_sum >= NReqW) ? ID_W'(grant_sum - NReqW) : ID_W'(grant_sum);
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    // FSM state, round-robin pointer and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, wait for consumer in RESP.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    state_d = StBusy;
                    cnt_d   = CntLoad;
                end
            end
            StBusy: begin
                if (cnt_q == 8'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                    // Start the next search just past the requester just served.
                    ptr_d   = (resp_id_q == LastId) ? '0 : resp_id_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs and datapath strobes; req_ready is forced low while in reset.
    always_comb begin
        accept    = (state_q == StIdle) && grant_vld;
        capture   = (state_q == StBusy) && (cnt_q == 8'd0);
        resp_done = (state_q == StResp) && resp_ready;
        busy      = (state_q != StIdle);
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = rst_n && accept && (grant_id == ID_W'(i));
        end
    end

    // Operand, response payload and response-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_a_q       <= '0;
            div_b_q       <= '0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_exc_q    <= 1'b0;
            resp_dbz_q    <= 1'b0;
            resp_valid_q  <= 1'b0;
        end else begin
            if (accept) begin
                div_a_q    <= sel_a;
                div_b_q    <= sel_b;
                resp_id_q  <= grant_id;
                resp_dbz_q <= (sel_b[30:23] == 8'h00);
            end
            if (capture) begin
                resp_result_q <= div_result;
                resp_exc_q    <= div_exception;
            end
            if (capture) begin
                resp_valid_q <= 1'b1;
            end else if (resp_done) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign div_a_operand  = div_a_q;
    assign div_b_operand  = div_b_q;
    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_result    = resp_result_q;
    assign resp_exception = resp_exc_q;
    assign resp_dbz       = resp_dbz_q;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Bench for fp_div_arbiter: transaction-level reference (grant order, accept
// timestamps, ideal quotient) checked every cycle, plus directed corner cases.
module tb_fp_div_arbiter;

    localparam int N = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Ideal-division divider model; exponents 0/255 mapped to simple specials.
    function automatic real to_real(input logic [31:0] x);
        logic [63:0] d;
        d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [63:0] d;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
        if (b[30:23] == 8'h00) return {s, 8'hFF, 23'h0};
        if (a[30:23] == 8'h00) return {s, 31'h0};
        d = $realtobits(to_real(a) / to_real(b));
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], d[51:29]};
    endfunction

    function automatic logic fexc(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    endfunction

    // Main DUT (DIV_CYCLES = 4)
    logic [N-1:0]    req_valid, req_ready;
    logic [32*N-1:0] req_a, req_b;
    logic [31:0]     div_a, div_b, div_result;
    logic            div_exception;
    logic            resp_valid, resp_ready, resp_exception, resp_dbz, busy;
    logic [1:0]      resp_id;
    logic [31:0]     resp_result;

    assign div_result    = fdiv(div_a, div_b);
    assign div_exception = fexc(div_a, div_b);

    fp_div_arbiter #(.N_REQ(N), .ID_W(2), .DIV_CYCLES(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .div_a_operand  (div_a),
        .div_b_operand  (div_b),
        .div_result     (div_result),
        .div_exception  (div_exception),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_result    (resp_result),
        .resp_exception (resp_exception),
        .resp_dbz       (resp_dbz),
        .busy           (busy)
    );

    // Second DUT (DIV_CYCLES = 1) with a divider whose output can be disturbed
    logic [N-1:0]    d1_valid, d1_ready;
    logic [32*N-1:0] d1_a, d1_b;
    logic [31:0]     d1_div_a, d1_div_b, d1_div_result, d1_glitch;
    logic            d1_div_exc, d1_resp_valid, d1_resp_ready, d1_resp_exc, d1_resp_dbz, d1_busy;
    logic [1:0]      d1_resp_id;
    logic [31:0]     d1_resp_result;

    assign d1_div_result = fdiv(d1_div_a, d1_div_b) ^ d1_glitch;
    assign d1_div_exc    = fexc(d1_div_a, d1_div_b);

    fp_div_arbiter #(.N_REQ(N), .ID_W(2), .DIV_CYCLES(1)) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (d1_valid),
        .req_ready      (d1_ready),
        .req_a          (d1_a),
        .req_b          (d1_b),
        .div_a_operand  (d1_div_a),
        .div_b_operand  (d1_div_b),
        .div_result     (d1_div_result),
        .div_exception  (d1_div_exc),
        .resp_valid     (d1_resp_valid),
        .resp_ready     (d1_resp_ready),
        .resp_id        (d1_resp_id),
        .resp_result    (d1_resp_result),
        .resp_exception (d1_resp_exc),
        .resp_dbz       (d1_resp_dbz),
        .busy           (d1_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_ptr = 0, m_id = 0, m_acc = 0;
    logic [31:0] m_a, m_b;
    int          done_cnt = 0;
    int          mode = 0;      // 0 one-shot, 1 continuous, 2 random
    int          last_grant = -1;
    bit          prev_rv = 0;
    int          rv_rise_cyc = 0;
    int          obs_gq[$];
    int          obs_aq[$];
    logic [31:0] obs_result;
    logic [1:0]  obs_id;
    logic        obs_exc, obs_dbz;

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(9))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            default: v[30:23] = 8'(100 + $urandom_range(54));
        endcase
        return v;
    endfunction

    task automatic apply_stim();
        if (last_grant >= 0) begin
            if (mode == 1) begin
                req_a[32*last_grant +: 32] = rand_op();
                req_b[32*last_grant +: 32] = rand_op();
            end else begin
                req_valid[last_grant] = 1'b0;
            end
            last_grant = -1;
        end
        if (mode == 2) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_a[32*i +: 32] = rand_op();
                    req_b[32*i +: 32] = rand_op();
                end
            end
            resp_ready = 1'($urandom_range(1));
        end
    endtask

    // Compare this cycle against the model, then advance the model over the edge.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int           g;
        bit           rv;
        exp_rdy = '0;
        g = -1;
        if (!m_busy) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("req_ready", req_ready, exp_rdy);
        check_eq("ready_onehot", ($countones(req_ready) <= 1), 1);
        check_eq("busy", busy, m_busy);
        rv = m_busy && (cyc >= m_acc + D + 1);
        check_eq("resp_valid", resp_valid, rv);
        if (m_busy && cyc > m_acc) begin
            check_eq("div_a", div_a, m_a);
            check_eq("div_b", div_b, m_b);
        end
        if (rv) begin
            check_eq("resp_id", resp_id, m_id);
            check_eq("resp_result", resp_result, fdiv(m_a, m_b));
            check_eq("resp_exception", resp_exception, fexc(m_a, m_b));
            check_eq("resp_dbz", resp_dbz, m_b[30:23] == 8'h00);
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                obs_gq.push_back(i);
                obs_aq.push_back(cyc);
            end
        end
        if (resp_valid && !prev_rv) rv_rise_cyc = cyc;
        prev_rv = resp_valid;
        if (g >= 0) begin
            m_busy = 1;
            m_id = g;
            m_a = req_a[32*g +: 32];
            m_b = req_b[32*g +: 32];
            m_acc = cyc;
            last_grant = g;
        end else if (rv && resp_ready) begin
            m_busy = 0;
            m_ptr = (m_id + 1) % N;
            done_cnt++;
            obs_result = resp_result;
            obs_id = resp_id;
            obs_exc = resp_exception;
            obs_dbz = resp_dbz;
        end
        cyc++;
    endtask

    // Entered and left at posedge+1 with this cycle's inputs already applied.
    task automatic cycle();
        #1;
        step();
        @(posedge clk);
        #1;
        apply_stim();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_div_a"}, div_a, 0);
        check_eq({tag, "_div_b"}, div_b, 0);
        check_eq({tag, "_resp_valid"}, resp_valid, 0);
        check_eq({tag, "_resp_id"}, resp_id, 0);
        check_eq({tag, "_resp_result"}, resp_result, 0);
        check_eq({tag, "_resp_exc"}, resp_exception, 0);
        check_eq({tag, "_resp_dbz"}, resp_dbz, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 4'b1111;
        resp_ready = 1'b0;
        last_grant = -1;
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n = 1'b1;
        m_busy = 0;
        m_ptr = 0;
        prev_rv = 0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        if (done_cnt < target) check_eq("done_timeout", done_cnt, target);
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = '0;
        resp_ready = 1'b1;
        while (m_busy && n < 40) begin
            cycle();
            n++;
        end
        if (m_busy) check_eq("drain_timeout", m_busy, 0);
    endtask

    task automatic one_shot(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid[id] = 1'b1;
        resp_ready = 1'b1;
        wait_done(done_cnt + 1, 40);
    endtask

    initial begin
        int exp_order[5];
        int n;
        exp_order = '{0, 1, 2, 3, 0};
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b0;
        d1_valid = '0;
        d1_a = '0;
        d1_b = '0;
        d1_resp_ready = 1'b0;
        d1_glitch = '0;
        mode = 0;

        // Reset and a single request: 6.0 / 3.0 from requester 1
        do_reset();
        obs_gq.delete();
        obs_aq.delete();
        one_shot(1, 32'h40C0_0000, 32'h4040_0000);
        check_eq("t1_result", obs_result, 32'h4000_0000);
        check_eq("t1_id", obs_id, 1);
        check_eq("t1_exc", obs_exc, 0);
        check_eq("t1_dbz", obs_dbz, 0);
        check_eq("t1_latency", rv_rise_cyc - (obs_aq.size() > 0 ? obs_aq[0] : -100), D + 1);

        // All requesters continuously valid
        do_reset();
        obs_gq.delete();
        obs_aq.delete();
        mode = 1;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = rand_op();
            req_b[32*i +: 32] = rand_op();
        end
        req_valid = 4'b1111;
        resp_ready = 1'b1;
        wait_done(done_cnt + 5, 80);
        check_eq("rr_count", obs_gq.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            check_eq("rr_order", (i < obs_gq.size()) ? obs_gq[i] : -1, exp_order[i]);
        end
        for (int i = 0; i < 4; i++) begin
            check_eq("rr_spacing",
                     (i + 1 < obs_aq.size()) ? obs_aq[i+1] - obs_aq[i] : -1, D + 2);
        end
        mode = 0;
        drain();

        // Backpressure: consumer stalls for 10 cycles with other requests waiting
        obs_gq.delete();
        resp_ready = 1'b0;
        req_a[127:96] = 32'h4120_0000;
        req_b[127:96] = 32'h4080_0000;
        req_valid[3] = 1'b1;
        n = 0;
        while (!resp_valid && n < 20) begin
            cycle();
            n++;
        end
        check_eq("bp_resp_seen", resp_valid, 1);
        req_a[31:0] = 32'h3F80_0000;
        req_b[31:0] = 32'h4000_0000;
        req_a[63:32] = 32'hC000_0000;
        req_b[63:32] = 32'h3F00_0000;
        req_valid[1:0] = 2'b11;
        repeat (10) cycle();
        check_eq("bp_no_grant", obs_gq.size(), 1);
        resp_ready = 1'b1;
        wait_done(done_cnt + 1, 3);
        check_eq("bp_result", obs_result, 32'h4020_0000);
        wait_done(done_cnt + 2, 40);
        check_eq("bp_order0", obs_gq.size() > 1 ? obs_gq[1] : -1, 0);
        check_eq("bp_order1", obs_gq.size() > 2 ? obs_gq[2] : -1, 1);
        check_eq("bp_neg_result", obs_result, 32'hC080_0000);
        drain();

        // Exception / divide-by-zero / sign
        one_shot(2, 32'h3F80_0000, 32'h7F80_0000);
        check_eq("exc_inf", obs_exc, 1);
        check_eq("exc_inf_dbz", obs_dbz, 0);
        one_shot(0, 32'h3F80_0000, 32'h0000_0000);
        check_eq("dbz_zero", obs_dbz, 1);
        check_eq("dbz_exc", obs_exc, 0);
        one_shot(3, 32'hC120_0000, 32'h40A0_0000);
        check_eq("neg_result", obs_result, 32'hC000_0000);
        check_eq("neg_exc", obs_exc, 0);
        drain();

        // Asynchronous reset while BUSY with cnt = 2
        req_a[127:96] = 32'h4000_0000;
        req_b[127:96] = 32'h3F80_0000;
        req_valid[3] = 1'b1;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        req_valid = 4'b0101;
        #1;
        check_reset_outputs("arst");
        m_busy = 0;
        m_ptr = 0;
        prev_rv = 0;
        last_grant = -1;
        @(posedge clk);
        #1;
        check_reset_outputs("arst_hold");
        rst_n = 1'b1;
        obs_gq.delete();
        resp_ready = 1'b1;
        wait_done(done_cnt + 2, 40);
        check_eq("arst_first_grant", obs_gq.size() > 0 ? obs_gq[0] : -1, 0);
        check_eq("arst_second_grant", obs_gq.size() > 1 ? obs_gq[1] : -1, 2);
        drain();

        // Randomised traffic with random backpressure
        mode = 2;
        repeat (400) cycle();
        mode = 0;
        drain();
        check_eq("rand_progress", done_cnt > 40, 1);

        // DIV_CYCLES = 1 instance: latency and capture isolation
        d1_a[95:64] = 32'h4100_0000;
        d1_b[95:64] = 32'h4000_0000;
        d1_valid = 4'b0100;
        #1;
        check_eq("d1_ready", d1_ready, 4'b0100);
        @(posedge clk);
        #1;
        d1_valid = '0;
        #1;
        check_eq("d1_rv_t1", d1_resp_valid, 0);
        check_eq("d1_busy_t1", d1_busy, 1);
        check_eq("d1_div_b", d1_div_b, 32'h4000_0000);
        @(posedge clk);
        #1;
        check_eq("d1_rv_t2", d1_resp_valid, 1);
        check_eq("d1_id", d1_resp_id, 2);
        check_eq("d1_result", d1_resp_result, 32'h4080_0000);
        d1_glitch = 32'h1234_5678;
        #1;
        check_eq("d1_hold_a", d1_resp_result, 32'h4080_0000);
        @(posedge clk);
        #1;
        check_eq("d1_hold_b", d1_resp_result, 32'h4080_0000);
        check_eq("d1_rv_hold", d1_resp_valid, 1);
        d1_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("d1_rv_done", d1_resp_valid, 0);
        check_eq("d1_busy_done", d1_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
